// File: rtl/sample_unloader_pkg.sv
// Shared definitions for the capture-buffer readout path.
// Holds the dump length, the buffer word-index width (shared with the capture
// buffer), the default sync header bytes, the unloader state encoding and a
// small byte-select helper.
package sample_unloader_pkg;

  // Capture buffer geometry: 4096 words of 16 one-bit IF samples each.
  localparam int unsigned SAMPLER_WORDS = 4096;
  localparam int unsigned WORD_IDX_W    = 12;

  typedef logic [WORD_IDX_W-1:0] word_idx_t;

  // Default sync header placed in front of every dump.
  localparam logic [7:0] HDR0_DEFAULT = 8'h47;
  localparam logic [7:0] HDR1_DEFAULT = 8'h50;

  typedef enum logic [2:0] {
    StIdle,
    StHdrA,
    StHdrB,
    StLatch,
    StSendHi,
    StSendLo
  } unloader_state_e;

  // Select the high or low byte of a buffer word.
  function automatic logic [7:0] word_byte(input logic [15:0] word, input logic hi);
    return hi ? word[15:8] : word[7:0];
  endfunction

endpackage

// File: rtl/sample_unloader.sv
// sample_unloader: streams the GPS capture buffer to the host link as bytes.
//
// On a start pulse the unit emits a two-byte sync header, then walks the
// capture buffer from its current read pointer, latching one 16-bit word at a
// time and sending it MSB byte first over a valid/ready byte interface.
// Exactly one sample_rd strobe is issued per word.
//
// Ports:
//   clk          system clock (shared with the capture buffer)
//   rst_n        asynchronous active-low reset
//   start        single-cycle dump request, ignored while busy
//   sample_word  capture buffer read data at the current read pointer
//   sample_rd    one-cycle read pointer advance strobe
//   out_data     byte to host link
//   out_valid    out_data valid
//   out_ready    host link accepts the byte when out_valid=1
//   busy         dump in progress
//   done         one-cycle pulse after the last byte of a dump is accepted
module sample_unloader
  import sample_unloader_pkg::*;
#(
  parameter int unsigned WORDS = SAMPLER_WORDS,
  parameter logic [7:0]  HDR0  = HDR0_DEFAULT,
  parameter logic [7:0]  HDR1  = HDR1_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] sample_word,
  output logic        sample_rd,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic        done
);

  localparam word_idx_t LAST_IDX = word_idx_t'(WORDS - 1);

  unloader_state_e state_q, state_d;
  logic [15:0]     hold_q, hold_d;
  word_idx_t       word_cnt_q, word_cnt_d;
  logic            done_d;

  logic            sample_rd_q, sample_rd_d;
  logic [7:0]      out_data_q, out_data_d;
  logic            out_valid_q, out_valid_d;
  logic            busy_q, busy_d;
  logic            done_q;

  // Next-state logic. out_ready is only honoured in states that present a
  // byte, so a transfer always coincides with out_valid=1.
  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    word_cnt_d = word_cnt_q;
    done_d     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d    = StHdrA;
          word_cnt_d = '0;
        end
      end
      StHdrA: begin
        if (out_ready) state_d = StHdrB;
      end
      StHdrB: begin
        if (out_ready) state_d = StLatch;
      end
      StLatch: begin
        // The buffer word has been stable since the previous strobe at least
        // two cycles ago, so it is captured without a wait state.
        hold_d  = sample_word;
        state_d = StSendHi;
      end
      StSendHi: begin
        if (out_ready) state_d = StSendLo;
      end
      StSendLo: begin
        if (out_ready) begin
          if (word_cnt_q == LAST_IDX) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end else begin
            word_cnt_d = word_cnt_q + 1'b1;
            state_d    = StLatch;
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs are computed from the next state so that every port is driven
  // straight from a flop, with no path from out_ready to out_valid/out_data.
  always_comb begin
    sample_rd_d = 1'b0;
    out_data_d  = 8'h00;
    out_valid_d = 1'b0;
    busy_d      = (state_d != StIdle);

    unique case (state_d)
      StHdrA: begin
        out_data_d  = HDR0;
        out_valid_d = 1'b1;
      end
      StHdrB: begin
        out_data_d  = HDR1;
        out_valid_d = 1'b1;
      end
      StLatch: begin
        sample_rd_d = 1'b1;
      end
      StSendHi: begin
        out_data_d  = word_byte(hold_d, 1'b1);
        out_valid_d = 1'b1;
      end
      StSendLo: begin
        out_data_d  = word_byte(hold_d, 1'b0);
        out_valid_d = 1'b1;
      end
      default: begin
        out_data_d  = 8'h00;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      hold_q      <= 16'h0000;
      word_cnt_q  <= '0;
      sample_rd_q <= 1'b0;
      out_data_q  <= 8'h00;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      word_cnt_q  <= word_cnt_d;
      sample_rd_q <= sample_rd_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign sample_rd = sample_rd_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
